// File: rtl/rv_fetch.sv
// rv32i instruction-fetch stage: PC register, single-outstanding imem request
// FSM, and the IF/ID pipeline register backed by a one-entry skid buffer.
module rv_fetch #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_fetch_imem_req,
  output logic [XLEN-1:0] o_fetch_imem_addr,
  input  logic            i_fetch_imem_ready,
  input  logic            i_fetch_imem_rvalid,
  input  logic [31:0]     i_fetch_imem_rdata,
  input  logic            i_fetch_stall,
  input  logic            i_fetch_redirect,
  input  logic [XLEN-1:0] i_fetch_redirect_pc,
  output logic            o_fetch_valid,
  output logic [31:0]     o_fetch_instr,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic [XLEN-1:0] o_fetch_pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;

  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  logic            accept;
  logic            resp_live;
  logic            advance;
  logic [XLEN-1:0] redirect_tgt;

  // A full skid blocks new requests, so a skid drain and a fresh response
  // can never land in the IF/ID register on the same edge.
  assign o_fetch_imem_req  = (state == S_REQ) & ~skid_valid & ~i_rst;
  assign o_fetch_imem_addr = pc;

  assign accept       = o_fetch_imem_req & i_fetch_imem_ready;
  assign resp_live    = (state == S_WAIT) & i_fetch_imem_rvalid & ~i_fetch_redirect;
  assign advance      = ~i_fetch_stall | ~if_valid;
  assign redirect_tgt = i_fetch_redirect_pc & ~XLEN'(3);

  // NOTE: every register below is updated with non-blocking assignments so
  // each reads the pre-edge value of the others, exactly like the flops do.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (i_fetch_redirect) begin
            pc    <= redirect_tgt;
            state <= accept ? S_DROP : S_REQ;
          end else if (accept) begin
            req_pc <= pc;
            pc     <= pc + XLEN'(4);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_fetch_redirect) begin
            pc    <= redirect_tgt;
            state <= i_fetch_imem_rvalid ? S_REQ : S_DROP;
          end else if (i_fetch_imem_rvalid) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (i_fetch_redirect) pc <= redirect_tgt;
          // The stale response retires the only outstanding request.
          if (i_fetch_imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else if (i_fetch_redirect) begin
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      skid_valid <= 1'b0;
    end else if (advance) begin
      if (skid_valid) begin
        if_valid   <= 1'b1;
        if_instr   <= skid_instr;
        if_pc      <= skid_pc;
        skid_valid <= 1'b0;
      end else if (resp_live) begin
        if_valid <= 1'b1;
        if_instr <= i_fetch_imem_rdata;
        if_pc    <= req_pc;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end else if (resp_live) begin
      skid_valid <= 1'b1;
      skid_instr <= i_fetch_imem_rdata;
      skid_pc    <= req_pc;
    end
  end

  assign o_fetch_valid    = if_valid;
  assign o_fetch_instr    = if_instr;
  assign o_fetch_pc       = if_pc;
  assign o_fetch_pc_plus4 = if_pc + XLEN'(4);

endmodule
